switch_port_sink: RTL and testbench

- Synthesizable receive end of the switch output (master) interface. Consumes one 8-bit packet per valid/ready handshake.
- Applies programmable pseudo-random backpressure.
- Checks that each packet's destination field matches the port it is attached to, and optionally checks the payload.
- Counts good and bad packets. Terminates on a packet limit or a stall timeout.
- One instance sits on each of the north, south, east and west outputs for traffic regression and on-chip self-test.

---
 rtl/switch_pkg.sv | 29 ++
 rtl/switch_port_sink_lfsr8.sv | 24 ++
 rtl/switch_port_sink.sv | 144 ++++++++++++++
 tb/tb_switch_port_sink.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared definitions for the switch output interface.
//   DATA_W / DEST_MSB / DEST_LSB : packet layout {dest[1:0], payload[5:0]}
//   PORT_*                       : destination encodings of the four outputs
//   sinkState_t                  : sink FSM states
//   lfsrStep()                   : one step of the 8-bit backpressure LFSR
package switch_pkg;

    localparam int DATA_W   = 8;
    localparam int DEST_MSB = 7;
    localparam int DEST_LSB = 6;

    localparam logic [1:0] PORT_NORTH = 2'b00;
    localparam logic [1:0] PORT_SOUTH = 2'b01;
    localparam logic [1:0] PORT_EAST  = 2'b10;
    localparam logic [1:0] PORT_WEST  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sinkState_t;

    // Fibonacci x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
    // Kept here so the sink can look one step ahead of the register.
    function automatic logic [7:0] lfsrStep(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/switch_port_sink_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR used for pseudo-random backpressure.
//   clk, rst  : clock, synchronous active-low reset (reset value = seed)
//   load      : reload seed (takes priority over en)
//   en        : advance one step
//   seed      : start value, must be nonzero
//   q         : current LFSR value
module lfsr8
    import switch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)      q <= seed;
        else if (load) q <= seed;
        else if (en)   q <= lfsrStep(q);
    end

endmodule

// File: rtl/switch_port_sink.sv
// switch_port_sink: receive end of one switch output port.
//   clk, rst      : clock, synchronous active-low reset
//   i_start       : start/restart a run (ignored while running)
//   i_valid/i_data: switch master handshake and {dest, payload}
//   o_ready       : registered sink ready
//   i_bp_en       : enable random backpressure
//   i_bp_thresh   : ready only when lfsr >= thresh
//   o_pkt_count   : packets accepted this run (saturating)
//   o_err_count   : accepted packets failing a check (saturating)
//   o_last_data   : data of the most recent transfer
//   o_busy/o_done : FSM in RUN / DONE
//   o_timeout     : run ended on stall timeout, sticky until restart
module switch_port_sink
    import switch_pkg::*;
#(
    parameter logic [1:0] PORT_ID     = PORT_SOUTH,
    parameter int         PKT_LIMIT   = 100,
    parameter int         CNT_W       = 16,
    parameter int         TIMEOUT     = 1000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter bit         CHK_PAYLOAD = 1'b0,
    parameter logic [5:0] EXP_PAYLOAD = 6'h25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_bp_en,
    input  logic [7:0]        i_bp_thresh,
    output logic [CNT_W-1:0]  o_pkt_count,
    output logic [CNT_W-1:0]  o_err_count,
    output logic [DATA_W-1:0] o_last_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

    sinkState_t         state;
    logic [STALL_W-1:0] stallCnt;
    logic [7:0]         lfsrQ;
    logic [7:0]         lfsrNext;
    logic               startRun;
    logic               xfer;
    logic               badPkt;
    logic               hitLimit;
    logic               readyNext;
    logic [CNT_W-1:0]   pktInc;
    logic [CNT_W-1:0]   errInc;

    assign startRun = i_start && (state != ST_RUN);
    assign xfer     = i_valid && o_ready;

    lfsr8 uLfsr (
        .clk  (clk),
        .rst  (rst),
        .load (startRun),
        .en   (state == ST_RUN),
        .seed (LFSR_SEED),
        .q    (lfsrQ)
    );

    // Value the LFSR register will hold after this edge, so the registered
    // ready always reflects the LFSR value it is paired with.
    always_comb begin
        lfsrNext = lfsrQ;
        if (startRun)             lfsrNext = LFSR_SEED;
        else if (state == ST_RUN) lfsrNext = lfsrStep(lfsrQ);
    end

    assign readyNext = !i_bp_en || (lfsrNext >= i_bp_thresh);

    always_comb begin
        badPkt = (i_data[DEST_MSB:DEST_LSB] != PORT_ID);
        if (CHK_PAYLOAD && (i_data[DEST_LSB-1:0] != EXP_PAYLOAD)) badPkt = 1'b1;
    end

    // Saturating increments.
    assign pktInc   = (&o_pkt_count) ? o_pkt_count : o_pkt_count + CNT_W'(1);
    assign errInc   = (&o_err_count) ? o_err_count : o_err_count + CNT_W'(1);
    assign hitLimit = (32'(pktInc) == 32'(PKT_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            o_ready     <= 1'b0;
            o_pkt_count <= '0;
            o_err_count <= '0;
            o_last_data <= '0;
            o_timeout   <= 1'b0;
            stallCnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state       <= ST_RUN;
                        o_pkt_count <= '0;
                        o_err_count <= '0;
                        o_timeout   <= 1'b0;
                        stallCnt    <= '0;
                        o_ready     <= readyNext;
                    end else begin
                        o_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        o_pkt_count <= pktInc;
                        if (badPkt) o_err_count <= errInc;
                        o_last_data <= i_data;
                        stallCnt    <= '0;
                        // Drop ready right after the limit packet so no
                        // extra one is taken while already in DONE.
                        if (hitLimit) begin
                            state   <= ST_DONE;
                            o_ready <= 1'b0;
                        end else begin
                            o_ready <= readyNext;
                        end
                    end else if (stallCnt == STALL_MAX) begin
                        state     <= ST_DONE;
                        o_timeout <= 1'b1;
                        o_ready   <= 1'b0;
                    end else begin
                        stallCnt <= stallCnt + STALL_W'(1);
                        o_ready  <= readyNext;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = (state == ST_RUN);
    assign o_done = (state == ST_DONE);

endmodule

// File: tb/tb_switch_port_sink.sv
// Bench for switch_port_sink: three instances with different parameters
// (default run, short limit/timeout, payload check with narrow counters)
// compared every cycle against a packet-level reference model, plus
// directed end-of-test checks.
module tb_switch_port_sink;

    logic       clk;
    logic       rst;
    logic       startV [3];
    logic       validV [3];
    logic [7:0] dataV  [3];
    logic       bpEn;
    logic [7:0] bpThresh;

    logic        ready0, busy0, done0, to0;
    logic [15:0] pkt0, err0;
    logic [7:0]  last0;
    logic        ready1, busy1, done1, to1;
    logic [15:0] pkt1, err1;
    logic [7:0]  last1;
    logic        ready2, busy2, done2, to2;
    logic [2:0]  pkt2, err2;
    logic [7:0]  last2;

    int nCmp = 0;
    int nMis = 0;

    // reference model state: 0 idle, 1 running, 2 done
    int         mSt [3];
    int         mCnt [3];
    int         mErr [3];
    int         mStall [3];
    int         mXfer [3];
    logic [7:0] mLast [3];
    logic [7:0] mLfsr [3];
    logic       mReady [3];
    logic       mTo [3];

    int lim  [3] = '{100, 10, 10};
    int tmo  [3] = '{1000, 20, 1000};
    int cmax [3] = '{65535, 65535, 7};
    bit chkP [3] = '{1'b0, 1'b0, 1'b1};

    switch_port_sink #(.PKT_LIMIT(100)) dut0 (
        .clk(clk), .rst(rst), .i_start(startV[0]), .i_valid(validV[0]), .o_ready(ready0),
        .i_data(dataV[0]), .i_bp_en(bpEn), .i_bp_thresh(bpThresh), .o_pkt_count(pkt0),
        .o_err_count(err0), .o_last_data(last0), .o_busy(busy0), .o_done(done0), .o_timeout(to0));

    switch_port_sink #(.PKT_LIMIT(10), .TIMEOUT(20)) dut1 (
        .clk(clk), .rst(rst), .i_start(startV[1]), .i_valid(validV[1]), .o_ready(ready1),
        .i_data(dataV[1]), .i_bp_en(bpEn), .i_bp_thresh(bpThresh), .o_pkt_count(pkt1),
        .o_err_count(err1), .o_last_data(last1), .o_busy(busy1), .o_done(done1), .o_timeout(to1));

    switch_port_sink #(.PKT_LIMIT(10), .CNT_W(3), .CHK_PAYLOAD(1'b1)) dut2 (
        .clk(clk), .rst(rst), .i_start(startV[2]), .i_valid(validV[2]), .o_ready(ready2),
        .i_data(dataV[2]), .i_bp_en(bpEn), .i_bp_thresh(bpThresh), .o_pkt_count(pkt2),
        .o_err_count(err2), .o_last_data(last2), .o_busy(busy2), .o_done(done2), .o_timeout(to2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial taps x^8,x^6,x^5,x^4 -> bits 7,5,4,3 of the register.
    function automatic logic [7:0] refLfsr(input logic [7:0] q);
        return {q[6:0], ^(q & 8'hB8)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic modelStep(input int k);
        logic x, bad;
        x = validV[k] && mReady[k];
        if (!rst) begin
            mSt[k] = 0; mCnt[k] = 0; mErr[k] = 0; mStall[k] = 0; mXfer[k] = 0;
            mLast[k] = 8'h00; mLfsr[k] = 8'hA5; mReady[k] = 1'b0; mTo[k] = 1'b0;
        end else if (mSt[k] == 1) begin
            mLfsr[k] = refLfsr(mLfsr[k]);
            if (x) begin
                mXfer[k]++;
                bad = (dataV[k][7:6] != 2'b01) || (chkP[k] && dataV[k][5:0] != 6'h25);
                if (mCnt[k] < cmax[k]) mCnt[k]++;
                if (bad && mErr[k] < cmax[k]) mErr[k]++;
                mLast[k] = dataV[k];
                mStall[k] = 0;
                if (mCnt[k] == lim[k]) begin
                    mSt[k] = 2; mReady[k] = 1'b0;
                end else begin
                    mReady[k] = !bpEn || (mLfsr[k] >= bpThresh);
                end
            end else if (mStall[k] == tmo[k] - 1) begin
                mSt[k] = 2; mTo[k] = 1'b1; mReady[k] = 1'b0;
            end else begin
                mStall[k]++;
                mReady[k] = !bpEn || (mLfsr[k] >= bpThresh);
            end
        end else if (startV[k]) begin
            mSt[k] = 1; mCnt[k] = 0; mErr[k] = 0; mTo[k] = 1'b0; mStall[k] = 0; mXfer[k] = 0;
            mLfsr[k] = 8'hA5;
            mReady[k] = !bpEn || (8'hA5 >= bpThresh);
        end else begin
            mReady[k] = 1'b0;
        end
    endtask

    task automatic checkDut(input int k, input logic r, input logic [15:0] p, input logic [15:0] e,
                            input logic [7:0] l, input logic b, input logic d, input logic t);
        chk($sformatf("d%0d.ready", k), 32'(r), 32'(mReady[k]));
        chk($sformatf("d%0d.pkt", k),   32'(p), 32'(mCnt[k]));
        chk($sformatf("d%0d.err", k),   32'(e), 32'(mErr[k]));
        chk($sformatf("d%0d.last", k),  32'(l), 32'(mLast[k]));
        chk($sformatf("d%0d.busy", k),  32'(b), 32'(mSt[k] == 1));
        chk($sformatf("d%0d.done", k),  32'(d), 32'(mSt[k] == 2));
        chk($sformatf("d%0d.tmo", k),   32'(t), 32'(mTo[k]));
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) modelStep(k);
        @(posedge clk);
        @(negedge clk);
        checkDut(0, ready0, pkt0, err0, last0, busy0, done0, to0);
        checkDut(1, ready1, pkt1, err1, last1, busy1, done1, to1);
        checkDut(2, ready2, 16'(pkt2), 16'(err2), last2, busy2, done2, to2);
    endtask

    initial begin
        int n;
        rst = 1'b0; bpEn = 1'b0; bpThresh = 8'h00;
        for (int k = 0; k < 3; k++) begin
            startV[k] = 1'b0; validV[k] = 1'b0; dataV[k] = 8'h00;
        end
        @(negedge clk);
        repeat (3) tick();
        chk("reset.ready", 32'(ready0), 0);
        chk("reset.pkt",   32'(pkt0), 0);
        rst = 1'b1;
        tick();

        // 1: continuous good traffic up to the 100-packet limit
        startV[0] = 1'b1; validV[0] = 1'b1; dataV[0] = 8'h75;
        tick();
        startV[0] = 1'b0;
        chk("t1.readyAfterStart", 32'(ready0), 1);
        n = 0;
        while (!done0 && n < 200) begin tick(); n++; end
        chk("t1.cycles", n, 100);
        chk("t1.pkt", 32'(pkt0), 100);
        chk("t1.err", 32'(err0), 0);
        chk("t1.done", 32'(done0), 1);
        chk("t1.ready", 32'(ready0), 0);
        chk("t1.last", 32'(last0), 32'h75);
        tick();
        chk("t1.noExtra", 32'(pkt0), 100);
        validV[0] = 1'b0;

        // 2: alternating good / wrong-destination packets, limit 10
        startV[1] = 1'b1; validV[1] = 1'b1; dataV[1] = 8'h75;
        tick();
        startV[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dataV[1] = (i % 2 == 1) ? 8'hB5 : 8'h75;
            tick();
        end
        chk("t2.pkt", 32'(pkt1), 10);
        chk("t2.err", 32'(err1), 5);
        chk("t2.done", 32'(done1), 1);
        chk("t2.last", 32'(last1), 32'hB5);

        // 5: no traffic, timeout 20 cycles after start
        validV[1] = 1'b0; startV[1] = 1'b1;
        tick();
        startV[1] = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin tick(); n++; end
        chk("t5.cycles", n, 20);
        chk("t5.tmo", 32'(to1), 1);
        chk("t5.pkt", 32'(pkt1), 0);

        // 3: payload check, then counter saturation on 3-bit counters
        startV[2] = 1'b1;
        tick();
        startV[2] = 1'b0;
        validV[2] = 1'b1; dataV[2] = 8'h65; tick();
        dataV[2] = 8'h66; tick();
        validV[2] = 1'b0; tick();
        chk("t3.pkt", 32'(pkt2), 2);
        chk("t3.err", 32'(err2), 1);
        chk("t3.last", 32'(last2), 32'h66);
        validV[2] = 1'b1; dataV[2] = 8'hB5;
        repeat (12) tick();
        validV[2] = 1'b0;
        chk("sat.pkt", 32'(pkt2), 7);
        chk("sat.err", 32'(err2), 7);
        chk("sat.busy", 32'(busy2), 1);

        // 6: reset mid-run at count 37, then restart from zero
        startV[0] = 1'b1; validV[0] = 1'b1; dataV[0] = 8'h75;
        tick();
        startV[0] = 1'b0;
        n = 0;
        while (pkt0 != 16'd37 && n < 200) begin tick(); n++; end
        chk("t6.reach37", 32'(pkt0), 37);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("t6.rst.ready", 32'(ready0), 0);
        chk("t6.rst.pkt", 32'(pkt0), 0);
        chk("t6.rst.last", 32'(last0), 0);
        chk("t6.rst.busy", 32'(busy0), 0);
        chk("t6.rst.done", 32'(done0), 0);
        startV[0] = 1'b1; tick(); startV[0] = 1'b0;
        repeat (5) tick();
        chk("t6.restart.pkt", 32'(pkt0), 5);
        rst = 1'b0; tick(); rst = 1'b1;
        validV[0] = 1'b0;

        // 4: random backpressure threshold 0x80, random traffic
        bpEn = 1'b1; bpThresh = 8'h80;
        startV[0] = 1'b1; tick(); startV[0] = 1'b0;
        chk("t4.firstReady", 32'(ready0), 1);
        for (int i = 0; i < 150; i++) begin
            validV[0] = 1'($urandom_range(0, 1));
            dataV[0]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'b01, 6'($urandom)};
            tick();
        end
        chk("t4.pktEqXfers", 32'(pkt0), mXfer[0]);

        // soak: random everything on all instances
        for (int i = 0; i < 500; i++) begin
            bpEn     = ($urandom_range(0, 3) != 0);
            bpThresh = 8'($urandom);
            rst      = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 3; k++) begin
                startV[k] = ($urandom_range(0, 15) == 0);
                validV[k] = 1'($urandom_range(0, 1));
                dataV[k]  = ($urandom_range(0, 1) == 0) ? 8'h65 : 8'($urandom);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule
